// File: rtl/bcd_timer_if.sv
// Control/status bundle for bcd_timer: load/run controls in, packed HH:MM:SS time and event flags out.
interface bcd_timer_if;
    logic        load;
    logic [31:0] load_val;
    logic        run;
    logic        mode;
    logic [31:0] value;
    logic        done;
    logic        expire;
    logic        load_err;

    modport master (output load, load_val, run, mode, input value, done, expire, load_err);
    modport slave  (input load, load_val, run, mode, output value, done, expire, load_err);
endinterface

// File: rtl/bcd_timer.sv
// HH:MM:SS BCD countdown / count-up timer with prescaled one-second tick,
// validated preset load, pause/resume and optional auto-reload on expiry.
module bcd_timer #(
    parameter int TICK_DIV    = 100000000,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd_timer_if.slave bus
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Per-digit maximum, packed {hr_10,hr_1,min_10,min_1,sec_10,sec_1}.
    localparam logic [23:0] LIM = 24'h995959;

    logic [1:0]    state;
    logic [23:0]   preset, cur, nxt, ld_dig, end_val, reload_val;
    logic [PW-1:0] presc;
    logic          mode_q, armed, expire_q, load_err_q;
    logic          ld_ok, at_end, tick;
    logic          unused_filler;

    function automatic logic [23:0] bcd_step(input logic [23:0] d, input logic up);
        logic [23:0] r;
        logic        c;
        r = d;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (up) begin
                    if (d[i*4 +: 4] == LIM[i*4 +: 4]) r[i*4 +: 4] = 4'd0;
                    else begin r[i*4 +: 4] = d[i*4 +: 4] + 4'd1; c = 1'b0; end
                end else begin
                    if (d[i*4 +: 4] == 4'd0) r[i*4 +: 4] = LIM[i*4 +: 4];
                    else begin r[i*4 +: 4] = d[i*4 +: 4] - 4'd1; c = 1'b0; end
                end
            end
        end
        return r;
    endfunction

    assign ld_dig        = {bus.load_val[31:24], bus.load_val[19:12], bus.load_val[7:0]};
    assign unused_filler = ^{bus.load_val[23:20], bus.load_val[11:8]};

    always_comb begin
        ld_ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (ld_dig[i*4 +: 4] > LIM[i*4 +: 4]) ld_ok = 1'b0;
    end

    assign end_val    = mode_q ? preset : 24'd0;
    assign reload_val = mode_q ? 24'd0  : preset;
    assign at_end     = (cur == end_val);
    assign tick       = (presc == PMAX);
    assign nxt        = bcd_step(cur, mode_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            preset     <= '0;
            cur        <= '0;
            mode_q     <= 1'b0;
            presc      <= '0;
            armed      <= 1'b0;
            expire_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            expire_q   <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (ld_ok) begin
                    preset <= ld_dig;
                    mode_q <= bus.mode;
                    cur    <= bus.mode ? 24'd0 : ld_dig;
                    presc  <= '0;
                    state  <= S_IDLE;
                    armed  <= 1'b1;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else begin
                case (state)
                    // armed keeps a post-reset block parked until software reloads it
                    S_IDLE:  if (bus.run && armed) state <= S_RUN;
                    S_PAUSE: if (bus.run) state <= S_RUN;
                    S_RUN: begin
                        if (at_end) begin
                            // already at the end value on entry: expire without a tick
                            if (!expire_q) begin
                                expire_q <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    cur   <= reload_val;
                                    presc <= '0;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                        end else if (!bus.run) begin
                            state <= S_PAUSE;
                        end else if (tick) begin
                            presc <= '0;
                            if (nxt == end_val) begin
                                expire_q <= 1'b1;
                                if (AUTO_RELOAD) cur <= reload_val;
                                else begin
                                    cur   <= nxt;
                                    state <= S_DONE;
                                end
                            end else begin
                                cur <= nxt;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.value    = {cur[23:16], 4'hf, cur[15:8], 4'hf, cur[7:0]};
    assign bus.done     = (state == S_DONE);
    assign bus.expire   = expire_q;
    assign bus.load_err = load_err_q;

endmodule

// File: doc/bcd_timer.md
BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per counted second (>=2).
REQ-002 Parameter AUTO_RELOAD, default 0, 1 = restart automatically on expiry.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  single-cycle request to capture load_val.
REQ-006 load_val  input  32  preset {hr_10,hr_1,4'hf,min_10,min_1,4'hf,sec_10,sec_1}; filler nibbles ignored.
REQ-007 run  input  1  level; 1 = count, 0 = pause.
REQ-008 mode  input  1  0 = count down to 00:00:00, 1 = count up from 00:00:00 to preset; sampled only at load.
REQ-009 value  output  32  current time, same packing as load_val, filler nibbles 4'hf.
REQ-010 done  output  1  level, high while in DONE.
REQ-011 expire  output  1  one-cycle pulse on each expiry.
REQ-012 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 Block SHALL hold a preset register, current BCD digits, a latched mode bit, a prescaler and a state of IDLE, RUN, PAUSE or DONE.
REQ-014 Load SHALL be accepted only if every hr/min-unit/sec-unit digit <=9 and min_10, sec_10 <=5; otherwise load_err SHALL pulse the following cycle and all state SHALL be unchanged.
REQ-015 Accepted load, in any state, SHALL: store preset, latch mode, set current = preset (mode 0) or 00:00:00 (mode 1), clear prescaler, enter IDLE, clear done; value reflects the new time the cycle after load.
REQ-016 IDLE -> RUN when run=1; PAUSE -> RUN when run=1; RUN -> PAUSE when run=0; DONE is left only by accepted load, or by auto-reload (REQ-022).
REQ-017 Prescaler SHALL advance only in RUN, hold in PAUSE/IDLE/DONE; it generates one internal tick when it reaches TICK_DIV-1, then returns to 0.
REQ-018 First tick after a load SHALL occur exactly TICK_DIV cycles after entering RUN; pause/resume SHALL not lose the accumulated prescaler count.
REQ-019 Mode 0 tick: decrement with BCD borrow chain sec_1 (9), sec_10 (5), min_1 (9), min_10 (5), hr_1 (9), hr_10; e.g. 10:00:00 -> 09:59:59.
REQ-020 Mode 1 tick: increment with BCD carry using the same digit limits; 09:59:59 -> 10:00:00.
REQ-021 On the tick whose result equals the end value (00:00:00 mode 0, preset mode 1) the block SHALL enter DONE, assert done, and pulse expire in the same cycle the new value appears.
REQ-022 With AUTO_RELOAD=1, expiry SHALL instead reload current as in REQ-015, stay in RUN, pulse expire, keep done low, prescaler restarts from 0.
REQ-023 Entering RUN when current already equals the end value (zero preset) SHALL go to DONE on the next cycle with one expire pulse, no tick needed.
REQ-024 Simultaneous load and tick: load SHALL win, tick discarded.
REQ-025 Value SHALL never leave 00:00:00..99:59:59; no wrap in either mode.
REQ-026 expire SHALL never assert in two consecutive cycles.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, preset and current 00:00:00, mode 0, prescaler 0, value 32'h00f00f00, done 0, expire 0, load_err 0.
REQ-028 Reset deasserted mid-count SHALL leave the block idle until a new load and run; no expire is produced by reset.

Verification (TICK_DIV=4 in bench)
REQ-029 Load 32'h00f01f05 mode 0, run=1 -> value steps 00:01:05, 00:01:04 ... 00:00:00 every 4 cycles; expire pulse once, done high.
REQ-030 Load 32'h10f00f00 mode 0, run -> next tick value 32'h09f59f59.
REQ-031 Load 32'h00f00f03 mode 1, run -> 00:00:01, 00:00:02, 00:00:03, done at 3rd tick.
REQ-032 Load 32'h00f00f60 -> load_err pulse, value unchanged; load with sec_1=4'ha -> load_err.
REQ-033 Run 2 cycles, pause 10 cycles, resume -> next tick exactly 2 cycles after resume.
REQ-034 AUTO_RELOAD=1, load 00:00:02 mode 0 -> expire every 8 cycles, done stays 0; rst_n low mid-run -> value 32'h00f00f00 immediately.
